hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS core; sits beside the ID stage and drives PC, IF/ID and ID/EX control.
- Detects load-use hazards and inserts a configurable number of bubbles (for multi-cycle data memory).
- Also flushes on taken branches, ignores register $0 and freezes the pipeline while memory is busy.
- Sequential stall FSM with bubble counter; optional performance counters.

Parameters:
- REG_ADDR_W, 5, register address width
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal 1..4
- CNT_W, 2, bubble counter width; must satisfy 2^CNT_W > LOAD_USE_CYCLES-1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RtAddr  input  REG_ADDR_W  load destination register
- IF_ID_RsAddr  input  REG_ADDR_W  ID-stage source rs
- IF_ID_RtAddr  input  REG_ADDR_W  ID-stage source rt
- IF_ID_UsesRt  input  1  ID instruction reads rt (0 for I-type ALU ops and loads)
- BranchTaken  input  1  branch resolved taken in EX this cycle
- MemBusy  input  1  data memory not ready; freeze the whole pipeline
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register write enable
- Stall  output  1  insert bubble into ID/EX (zero control)
- Flush_IF_ID  output  1  clear IF/ID
- Flush_ID_EX  output  1  clear ID/EX
- Freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
- StallCount  output  32  load-use bubble cycles (optional feature)
- FlushCount  output  32  branch flushes (optional feature)

Behaviour:
- Hazard detect (combinational): hit = ID_EX_MemRead && ID_EX_RtAddr!=0 && (ID_EX_RtAddr==IF_ID_RsAddr || (IF_ID_UsesRt && ID_EX_RtAddr==IF_ID_RtAddr)).
- FSM states: IDLE, STALL. Counter cnt[CNT_W-1:0].
- IDLE, hit=1, no BranchTaken:
  - Outputs this cycle: Stall=1, PCWrite=0, IF_ID_Write=0.
  - If LOAD_USE_CYCLES>1: next state STALL, cnt<=LOAD_USE_CYCLES-2.
  - Otherwise remain IDLE.
- STALL: Stall=1, PCWrite=0, IF_ID_Write=0 regardless of hit. If cnt==0 go to IDLE, else cnt<=cnt-1.
  - Total bubbles per hazard = exactly LOAD_USE_CYCLES consecutive cycles.
- Outputs: Mealy in the IDLE detect cycle, state-driven in STALL.
- BranchTaken (priority over load-use):
  - Flush_IF_ID=1, Flush_ID_EX=1, Stall=0, PCWrite=1, IF_ID_Write=1 for that cycle.
  - FSM forced to IDLE, cnt<=0; any pending bubbles are cancelled.
- MemBusy (highest priority):
  - Freeze=1, PCWrite=0, IF_ID_Write=0, Stall=0, flushes=0.
  - FSM state and cnt hold; a BranchTaken or hit in that cycle is ignored (the source stages are frozen and re-present it).
- Idle outputs (no hazard, no branch, no busy): PCWrite=1, IF_ID_Write=1, all others 0.
- Reset (async, any state, including mid-STALL):
  - State IDLE, cnt 0, counters 0.
  - While rst=1, outputs forced to PCWrite=1, IF_ID_Write=1, Stall=0, Flush_*=0, Freeze=0.
- Back-to-back loads: a new hit in the first IDLE cycle after STALL starts a new sequence with no gap cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCount increments by 1 each cycle Stall=1.
  - FlushCount increments by 1 each cycle Flush_IF_ID=1.
  - Both hold while MemBusy=1; both wrap at 2^32.
- Undefined: StallCount and FlushCount tied to 0 and no counter flops; ports stay present.

Test Plan:
- LOAD_USE_CYCLES=1: ID_EX_MemRead=1, RtAddr=8, IF_ID_RsAddr=8 for 1 cycle -> Stall=1, PCWrite=0, IF_ID_Write=0 that cycle only; next cycle with MemRead=0 -> all idle values.
- LOAD_USE_CYCLES=3, RtAddr=9 == IF_ID_RtAddr, UsesRt=1 -> Stall=1 for exactly 3 cycles (inputs bubbled after the first), then IDLE; StallCount=3 with HAZARD_PERF_CNT_EN. UsesRt=0 with the same addresses -> no stall.
- RtAddr=0 == RsAddr=0 with MemRead=1 -> no stall.
- LOAD_USE_CYCLES=3, BranchTaken=1 in the 2nd stall cycle -> Flush_IF_ID=Flush_ID_EX=1, Stall=0 that cycle; next cycle IDLE, no remaining bubbles; FlushCount=1.
- MemBusy=1 for 4 cycles mid-STALL (cnt=1) -> Freeze=1, Stall=0 throughout, then 2 more stall cycles after release; StallCount excludes frozen cycles.
- rst pulse asynchronously mid-STALL -> outputs immediately PCWrite=1, Stall=0; counters 0; FSM IDLE after release.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Load-use / branch / memory-busy hazard controller for the 5-stage MIPS pipeline.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] i_ID_EX_RtAddr,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_RsAddr,
  input  logic [REG_ADDR_W-1:0] i_IF_ID_RtAddr,
  input  logic                  i_IF_ID_UsesRt,
  input  logic                  i_BranchTaken,
  input  logic                  i_MemBusy,
  output logic                  o_PCWrite,
  output logic                  o_IF_ID_Write,
  output logic                  o_Stall,
  output logic                  o_Flush_IF_ID,
  output logic                  o_Flush_ID_EX,
  output logic                  o_Freeze,
  output logic [31:0]           o_StallCount,
  output logic [31:0]           o_FlushCount
);

  typedef enum logic {ST_IDLE = 1'b0, ST_STALL = 1'b1} state_t;

  // Bubbles still owed after the detect cycle, minus one (STALL exits when cnt hits 0).
  localparam logic [CNT_W-1:0] LP_CNT_INIT =
    (LOAD_USE_CYCLES > 1) ? CNT_W'(LOAD_USE_CYCLES - 2) : {CNT_W{1'b0}};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_hit;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_stall;
  logic w_flush;
  logic w_freeze;

  // Load-use hazard detect; writes to $0 never create a dependency.
  always_comb begin
    w_hit = 1'b0;
    if (i_ID_EX_MemRead && (i_ID_EX_RtAddr != {REG_ADDR_W{1'b0}})) begin
      w_hit = (i_ID_EX_RtAddr == i_IF_ID_RsAddr) ||
              (i_IF_ID_UsesRt && (i_ID_EX_RtAddr == i_IF_ID_RtAddr));
    end else begin
      w_hit = 1'b0;
    end
  end

  // Output decode: reset, then memory busy, then branch, then load-use stall.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_stall       = 1'b0;
    w_flush       = 1'b0;
    w_freeze      = 1'b0;
    if (i_rst) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
    end else if (i_MemBusy) begin
      w_freeze      = 1'b1;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
    end else if (i_BranchTaken) begin
      w_flush       = 1'b1;
    end else if ((r_state == ST_STALL) || w_hit) begin
      w_stall       = 1'b1;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
    end else begin
      w_stall       = 1'b0;
    end
  end

  // Stall FSM and bubble counter; everything holds while memory is busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_MemBusy) begin
      r_state <= r_state;
      r_cnt   <= r_cnt;
    end else if (i_BranchTaken) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit && (LOAD_USE_CYCLES > 1)) begin
            r_state <= ST_STALL;
            r_cnt   <= LP_CNT_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Performance counters; stall/flush are already suppressed while frozen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign o_StallCount = r_stall_count;
  assign o_FlushCount = r_flush_count;
`else
  assign o_StallCount = 32'd0;
  assign o_FlushCount = 32'd0;
`endif

  assign o_PCWrite     = w_pc_write;
  assign o_IF_ID_Write = w_if_id_write;
  assign o_Stall       = w_stall;
  assign o_Flush_IF_ID = w_flush;
  assign o_Flush_ID_EX = w_flush;
  assign o_Freeze      = w_freeze;

endmodule
